// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters driving an 8:1 mux select,
// with a bounded hold time per grant and a registered data output.
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       y,
    output logic       y_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [3:0] HMAX = 4'(HOLD_MAX);

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [2:0] sel_q;
    logic [3:0] cnt_q;
    logic [7:0] gnt_q;
    logic       busy_q;
    logic       y_q;
    logic       yv_q;

    logic [2:0] base_d;
    logic [2:0] cand_d;
    logic [2:0] win_d;
    logic       found_d;
    logic       hold_d;

    // Scan base+1 .. base+8; walking downward lets the nearest hit win.
    always_comb begin
        base_d  = (state_q == GRANT) ? sel_q : ptr_q;
        found_d = 1'b0;
        win_d   = base_d;
        cand_d  = base_d;
        for (int k = 7; k >= 0; k--) begin
            cand_d = base_d + 3'(k) + 3'd1;
            if (req[cand_d]) begin
                found_d = 1'b1;
                win_d   = cand_d;
            end
        end
        hold_d = (state_q == GRANT) && req[sel_q] && (cnt_q < HMAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd7;
            sel_q   <= 3'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 8'h00;
            busy_q  <= 1'b0;
            y_q     <= 1'b0;
            yv_q    <= 1'b0;
        end else begin
            y_q  <= busy_q & d[sel_q];
            yv_q <= busy_q;
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= GRANT;
                        gnt_q   <= 8'b1 << win_d;
                        sel_q   <= win_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'd1;
                    end
                end
                GRANT: begin
                    if (hold_d) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        ptr_q <= sel_q;
                        if (found_d) begin
                            gnt_q <= 8'b1 << win_d;
                            sel_q <= win_d;
                            cnt_q <= 4'd1;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 8'h00;
                            busy_q  <= 1'b0;
                            cnt_q   <= 4'd0;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign y       = y_q;
    assign y_valid = yv_q;

endmodule
